// File: rtl/rgb2yuv_pkg.sv
// Shared definitions for the RGB->YUV converter: BT.601/BT.709 coefficients
// (8 fractional bits), fixed-point scaling constants and the mode enum.
package rgb2yuv_pkg;

    typedef enum logic {
        MODE_601 = 1'b0,
        MODE_709 = 1'b1
    } mode_e;

    localparam int FRAC_BITS = 8;
    localparam int ROUND_K   = 1 << (FRAC_BITS - 1);
    localparam int COEF_W    = 9;
    localparam int NCOEF     = 9;

    typedef logic signed [COEF_W-1:0] coef_t;

    localparam coef_t C601_YR =  9'sd77;
    localparam coef_t C601_YG =  9'sd150;
    localparam coef_t C601_YB =  9'sd29;
    localparam coef_t C601_UR = -9'sd43;
    localparam coef_t C601_UG = -9'sd85;
    localparam coef_t C601_UB =  9'sd128;
    localparam coef_t C601_VR =  9'sd128;
    localparam coef_t C601_VG = -9'sd107;
    localparam coef_t C601_VB = -9'sd21;

    localparam coef_t C709_YR =  9'sd54;
    localparam coef_t C709_YG =  9'sd183;
    localparam coef_t C709_YB =  9'sd19;
    localparam coef_t C709_UR = -9'sd29;
    localparam coef_t C709_UG = -9'sd99;
    localparam coef_t C709_UB =  9'sd128;
    localparam coef_t C709_VR =  9'sd128;
    localparam coef_t C709_VG = -9'sd116;
    localparam coef_t C709_VB = -9'sd12;

    // Index order: 0..2 = Y(R,G,B), 3..5 = U(R,G,B), 6..8 = V(R,G,B).
    function automatic coef_t coef_sel(input mode_e mode, input int idx);
        coef_t c;
        c = '0;
        if (mode == MODE_709) begin
            case (idx)
                0: c = C709_YR;
                1: c = C709_YG;
                2: c = C709_YB;
                3: c = C709_UR;
                4: c = C709_UG;
                5: c = C709_UB;
                6: c = C709_VR;
                7: c = C709_VG;
                8: c = C709_VB;
                default: c = '0;
            endcase
        end else begin
            case (idx)
                0: c = C601_YR;
                1: c = C601_YG;
                2: c = C601_YB;
                3: c = C601_UR;
                4: c = C601_UG;
                5: c = C601_UB;
                6: c = C601_VR;
                7: c = C601_VG;
                8: c = C601_VB;
                default: c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/rgb2yuv_frame_ctrl.sv
// Frame controller: arms on start, admits exactly NPIX pixels, then waits for
// NPIX output transfers and pulses done on the last one.
module rgb2yuv_frame_ctrl #(
    parameter int NPIX = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic in_fire,
    input  logic out_fire,
    output logic accept_en,
    output logic done
);

    localparam int CW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        accept_en = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                accept_en = 1'b1;
                if (in_fire) begin
                    if (in_cnt_q == LAST) begin
                        in_cnt_d = '0;
                        state_d  = FLUSH;
                    end else begin
                        in_cnt_d = in_cnt_q + CW'(1);
                    end
                end
                // Early pixels can leave the pipe while later ones still enter.
                if (out_fire) begin
                    out_cnt_d = out_cnt_q + CW'(1);
                end
            end
            FLUSH: begin
                if (out_fire) begin
                    if (out_cnt_q == LAST) begin
                        out_cnt_d = '0;
                        done      = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/rgb2yuv_pipe.sv
// Three-stage streaming RGB->YUV converter with valid/ready on both sides.
// Define RGB2YUV_FRAME_EN to add start/done ports and the NPIX frame controller.
module rgb2yuv_pipe
    import rgb2yuv_pkg::*;
#(
    parameter int DW   = 9,
    parameter int NPIX = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mode,
    input  logic [DW-1:0] inportR,
    input  logic [DW-1:0] inportG,
    input  logic [DW-1:0] inportB,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] outportY,
    output logic [DW-1:0] outportU,
    output logic [DW-1:0] outportV
`ifdef RGB2YUV_FRAME_EN
    ,
    input  logic          start,
    output logic          done
`endif
);

    localparam int PW = DW + 10;
    localparam int SW = DW + 12;
    localparam logic signed [SW-1:0] RND_S  = SW'(ROUND_K);
    localparam logic signed [SW-1:0] HALF_S = SW'(1 << (DW - 1));
    localparam logic signed [SW-1:0] MAX_S  = SW'((1 << DW) - 1);

    logic en;
    logic in_fire;
    logic accept_en;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s3_valid_q, s3_valid_d;

    logic [DW-1:0]        comp   [3];
    coef_t                coef_c [NCOEF];
    logic signed [PW-1:0] prod_d [NCOEF];
    logic signed [PW-1:0] prod_q [NCOEF];
    logic signed [SW-1:0] sum_d  [3];
    logic signed [SW-1:0] sum_q  [3];
    logic signed [SW-1:0] rnd_c  [3];
    logic signed [SW-1:0] shf_c  [3];
    logic [DW-1:0]        res_d  [3];
    logic [DW-1:0]        res_q  [3];

    function automatic logic signed [SW-1:0] sx(input logic signed [PW-1:0] p);
        return {{(SW-PW){p[PW-1]}}, p};
    endfunction

    // Whole pipe moves in lockstep; it only stalls when S3 holds an unaccepted pixel.
    assign en       = !s3_valid_q || out_ready;
    assign in_ready = en && accept_en;
    assign in_fire  = in_valid && in_ready;

    assign comp[0] = inportR;
    assign comp[1] = inportG;
    assign comp[2] = inportB;

`ifdef RGB2YUV_FRAME_EN
    logic out_fire;
    assign out_fire = out_valid && out_ready;

    rgb2yuv_frame_ctrl #(
        .NPIX(NPIX)
    ) u_frame_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_fire  (in_fire),
        .out_fire (out_fire),
        .accept_en(accept_en),
        .done     (done)
    );
`else
    assign accept_en = 1'b1;

    // NPIX only matters for the frame controller; free-running builds ignore it.
    if (NPIX < 1) begin : g_npix_unused
    end
`endif

    // S1: mode chosen at the input transfer is baked into the registered products.
    always_comb begin
        for (int i = 0; i < NCOEF; i++) begin
            coef_c[i] = coef_sel(mode_e'(in_mode), i);
            prod_d[i] = $signed({{(PW-DW){1'b0}}, comp[i % 3]})
                      * $signed({{(PW-COEF_W){coef_c[i][COEF_W-1]}}, coef_c[i]});
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            sum_d[k] = sx(prod_q[3*k]) + sx(prod_q[3*k+1]) + sx(prod_q[3*k+2]);
        end
    end

    // S3: round-half-up via +128 and floor shift, chroma offset, then saturate.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rnd_c[k] = sum_q[k] + RND_S;
            shf_c[k] = rnd_c[k] >>> FRAC_BITS;
            if (k != 0) begin
                shf_c[k] = shf_c[k] + HALF_S;
            end
            if (shf_c[k] < 0) begin
                res_d[k] = '0;
            end else if (shf_c[k] > MAX_S) begin
                res_d[k] = {DW{1'b1}};
            end else begin
                res_d[k] = shf_c[k][DW-1:0];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s3_valid_d = s3_valid_q;
        if (en) begin
            s1_valid_d = in_fire;
            s2_valid_d = s1_valid_q;
            s3_valid_d = s2_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCOEF; i++) begin
                prod_q[i] <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                sum_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < NCOEF; i++) begin
                prod_q[i] <= prod_d[i];
            end
            for (int k = 0; k < 3; k++) begin
                sum_q[k] <= sum_d[k];
                res_q[k] <= res_d[k];
            end
        end
    end

    assign out_valid = s3_valid_q;
    assign outportY  = res_q[0];
    assign outportU  = res_q[1];
    assign outportV  = res_q[2];

endmodule

// File: tb/tb_rgb2yuv_pipe.sv
// Directed bench for rgb2yuv_pipe (DW = 9) with hand-computed YUV vectors.
// With RGB2YUV_FRAME_EN defined it runs the frame-controller sequence instead.
module tb_rgb2yuv_pipe;

    localparam int DW = 9;
    localparam int NV = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_mode = 1'b0;
    logic [DW-1:0] r_in = '0;
    logic [DW-1:0] g_in = '0;
    logic [DW-1:0] b_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] y_out;
    logic [DW-1:0] u_out;
    logic [DW-1:0] v_out;
`ifdef RGB2YUV_FRAME_EN
    logic          start = 1'b0;
    logic          done;
`endif

    always #5 clk = ~clk;

    rgb2yuv_pipe #(
        .DW  (DW),
        .NPIX(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .inportR  (r_in),
        .inportG  (g_in),
        .inportB  (b_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .outportY (y_out),
        .outportU (u_out),
        .outportV (v_out)
`ifdef RGB2YUV_FRAME_EN
        ,
        .start    (start),
        .done     (done)
`endif
    );

    // Vectors: mode, R, G, B and the expected Y, U, V worked out by hand.
    int v_mode [NV] = '{0,   0,   1,   1,   0,   1,   0,   1  };
    int v_r    [NV] = '{511, 511, 0,   511, 0,   0,   100, 100};
    int v_g    [NV] = '{511, 0,   0,   0,   0,   511, 200, 200};
    int v_b    [NV] = '{511, 0,   0,   0,   511, 0,   50,  50 };
    int e_y    [NV] = '{511, 154, 0,   108, 58,  365, 153, 168};
    int e_u    [NV] = '{256, 170, 256, 198, 511, 58,  198, 192};
    int e_v    [NV] = '{256, 511, 256, 511, 214, 24,  218, 213};

    int n_cmp = 0;
    int n_bad = 0;
    int n_in  = 0;
    int n_out = 0;
    int cur_idx = 0;
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input int idx);
        cur_idx = idx;
        in_mode = v_mode[idx][0];
        r_in    = DW'(v_r[idx]);
        g_in    = DW'(v_g[idx]);
        b_in    = DW'(v_b[idx]);
    endtask

    // One clock: called just after a falling edge with inputs already driven.
    task automatic cycle(output bit fin, output bit fout);
        int idx;
        #1;
        fin  = in_valid && in_ready;
        fout = out_valid && out_ready;
        if (fout) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", out_valid, 0);
            end else begin
                idx = exp_q.pop_front();
                check($sformatf("pix%0d_y", idx), y_out, e_y[idx]);
                check($sformatf("pix%0d_u", idx), u_out, e_u[idx]);
                check($sformatf("pix%0d_v", idx), v_out, e_v[idx]);
                $display("out pixel %0d: Y=%0d U=%0d V=%0d", idx, y_out, u_out, v_out);
            end
        end
        if (fin) begin
            exp_q.push_back(cur_idx);
            n_in++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit fi;
        bit fo;
        int p;
        int base;
        int acc;
        int dcnt;
        logic [DW-1:0] hy;
        logic [DW-1:0] hu;
        logic [DW-1:0] hv;
        fi = 1'b0; fo = 1'b0; p = 0; base = 0; acc = 0; dcnt = 0;
        hy = '0; hu = '0; hv = '0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y_out, 0);
        check("rst_u", u_out, 0);
        check("rst_v", v_out, 0);
`ifndef RGB2YUV_FRAME_EN
        check("rst_in_ready", in_ready, 1);
`else
        check("idle_in_ready", in_ready, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

`ifndef RGB2YUV_FRAME_EN
        // Latency: out_valid rises exactly three cycles after the transfer.
        set_pix(0);
        in_valid = 1'b1;
        cycle(fi, fo);
        check("lat_accept", fi, 1);
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check($sformatf("lat_valid_c%0d", k), out_valid, (k == 3));
            cycle(fi, fo);
        end

        // Back-to-back pixels with alternating modes.
        for (int i = 1; i < NV; i++) begin
            set_pix(i);
            in_valid = 1'b1;
            cycle(fi, fo);
        end
        in_valid = 1'b0;
        repeat (4) cycle(fi, fo);
        check("stream_drained", exp_q.size(), 0);

        // Backpressure: out_ready low for 5 cycles while input stays valid.
        p = 0;
        for (int c = 0; c < 24; c++) begin
            out_ready = !(c >= 4 && c < 9);
            in_valid  = (p < 12);
            set_pix(p % NV);
            if (c >= 4 && c < 9) begin
                #1;
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                if (c == 4) begin
                    check("stall_front_y", y_out, e_y[exp_q[0]]);
                    hy = y_out; hu = u_out; hv = v_out;
                end else begin
                    check("stall_hold", {y_out, u_out, v_out}, {hy, hu, hv});
                end
            end
            cycle(fi, fo);
            if (fi) p++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle(fi, fo);
        check("stall_all_sent", p, 12);
        check("stall_drained", exp_q.size(), 0);
        check("in_out_balance", n_out, n_in);

        // Reset with pixels in flight discards them.
        set_pix(6);
        in_valid = 1'b1;
        cycle(fi, fo);
        set_pix(7);
        cycle(fi, fo);
        in_valid = 1'b0;
        cycle(fi, fo);
        #1;
        check("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_y", y_out, 0);
        check("mid_rst_u", u_out, 0);
        check("mid_rst_v", v_out, 0);
        check("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = n_out;
        set_pix(5);
        in_valid = 1'b1;
        cycle(fi, fo);
        in_valid = 1'b0;
        repeat (5) cycle(fi, fo);
        check("post_rst_out_count", n_out - base, 1);
        check("post_rst_drained", exp_q.size(), 0);
`else
        // Frame mode, NPIX = 4: nothing accepted until start.
        out_ready = 1'b1;
        set_pix(0);
        in_valid = 1'b1;
        cycle(fi, fo);
        check("idle_no_accept", fi, 0);
        in_valid = 1'b0;
        start = 1'b1;
        cycle(fi, fo);
        start = 1'b0;
        base = n_out;
        acc  = 0;
        dcnt = 0;
        p    = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid = (p < 6);
            set_pix(p % NV);
            #1;
            if (done) begin
                dcnt++;
                check("done_on_4th_out", n_out - base + 1, 4);
                check("done_with_transfer", out_valid && out_ready, 1);
            end
            if (acc == 4) begin
                check("frame_in_ready_low", in_ready, 0);
            end
            cycle(fi, fo);
            if (fi) begin
                acc++;
                p++;
            end
        end
        check("frame_accepted", acc, 4);
        check("frame_done_count", dcnt, 1);
        check("frame_outputs", n_out - base, 4);
        check("frame_drained", exp_q.size(), 0);
        in_valid = 1'b1;
        #1;
        check("after_frame_in_ready", in_ready, 0);
        in_valid = 1'b0;
        start = 1'b1;
        cycle(fi, fo);
        start = 1'b0;
        #1;
        check("rearm_in_ready", in_ready, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rgb2yuv_pipe.md
Name: rgb2yuv_pipe

Overview:
- Streaming, fully pipelined RGB to YUV colour-space converter with valid/ready handshakes on input and output. Accepts one pixel per clock.
- Successor to the start/done controller+datapath converter:
  - data width is parametrised;
  - BT.601 / BT.709 coefficient sets are selectable per pixel;
  - output is saturated;
  - backpressure is supported.
- Sits between the pixel source and downstream YUV consumers.

Parameters:
- DW, 9, width of each R/G/B input and Y/U/V output component (unsigned), legal range 6..12.
- NPIX, 64, pixels per frame; used only with RGB2YUV_FRAME_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  converter can accept a pixel.
- in_mode  in  1  coefficient set: 0 = BT.601, 1 = BT.709; sampled with the pixel.
- inportR / inportG / inportB  in  DW each  input components.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- outportY / outportU / outportV  out  DW each  output components.

Behaviour:
- Reset is asynchronous and active-low (rst_n), with a single clock (clk). On reset:
  - all stage valid bits = 0;
  - out_valid = 0;
  - outportY/U/V = 0;
  - in_ready = 1.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline: 3 stages, S1 → S2 → S3. Latency is 3 cycles from input transfer to out_valid, when there is no stall.
- Advance enable: en = !s3_valid || out_ready. All stages advance together when en = 1. in_ready = en, which is combinational from out_ready.
- S1: register 9 signed products per pixel. Width: DW+1 unsigned operand times 9-bit signed coefficient, giving a DW+10 bit signed product. Also register the mode bit.
- S2: three signed sums, each DW+12 bits.
- S3:
  - add 128 to each sum, then arithmetic shift right by 8 (floor);
  - add 2^(DW-1) to U and V;
  - clamp each result to [0, 2^DW-1];
  - register the result to the outputs.
- Coefficients use 8 fractional bits:
  - BT.601: Y = 77,150,29; U = -43,-85,128; V = 128,-107,-21.
  - BT.709: Y = 54,183,19; U = -29,-99,128; V = 128,-116,-12.
- Stage valid bits shift with en; a bubble carries valid = 0.
- Data registers hold their value while en = 0. Outputs stay stable while out_valid && !out_ready.
- Mode can change pixel to pixel; each pixel uses the mode sampled at its own input transfer.
- Simultaneous in and out transfer while the pipeline is full: throughput is 1 pixel per clock, with no bubble.
- Reset mid-stream: all in-flight pixels are discarded, with no partial output.

Optional Feature:
- Macro RGB2YUV_FRAME_EN.
- When defined, two ports are added:
  - start  in  1: one-cycle pulse that arms a frame;
  - done  out  1: one-cycle pulse on the output transfer of pixel NPIX.
- A frame controller FSM is added:
  - States: IDLE, RUN, FLUSH.
  - IDLE → RUN on start. In IDLE, in_ready = 0.
  - In RUN, an input counter counts accepted pixels. At NPIX accepted pixels → FLUSH, and in_ready is forced to 0.
  - In FLUSH, an output counter counts output transfers. At NPIX, done = 1 for one cycle → IDLE.
  - start outside IDLE is ignored.
- Reset values: done = 0, state = IDLE, counters = 0.
- When not defined: no start/done ports, and the converter is free-running.

Decomposition:
- Package rgb2yuv_pkg holds:
  - coefficient constants for both standards;
  - the 8-bit fraction shift and the rounding constant;
  - the mode enum (MODE_601 = 0, MODE_709 = 1).
- One natural sub-module, rgb2yuv_frame_ctrl: the FSM plus counters, instantiated only under RGB2YUV_FRAME_EN. The datapath stays in rgb2yuv_pipe.

Test Plan (DW = 9):
- Mode 0, R=G=B=511 → Y = 511, U = 256, V = 256, with out_valid asserted exactly 3 cycles after input transfer.
- Mode 0, R=511, G=0, B=0 → Y = 154, U = 170. Raw V = 512 saturates to 511.
- Mode 1, R=G=B=0 → Y = 0, U = 256, V = 256. Then mode 0 and mode 1 pixels are sent back-to-back, and each output matches its own mode.
- Continuous in_valid with out_ready held low 5 cycles → in_ready falls, 3 pixels are held, the outputs are stable, no pixel is lost or duplicated, and the stream resumes in order.
- rst_n asserted with 2 pixels in flight → out_valid = 0 immediately and the outputs are 0. After release, the first output is the first new pixel.
- RGB2YUV_FRAME_EN, NPIX = 4, start pulse, 6 pixels offered → exactly 4 accepted, done pulses once on the 4th output transfer, and in_ready = 0 until the next start.
